// File: rtl/perf_report_pkg.sv
// Shared constants, state encoding and checksum helper for the performance-report UART.
package perf_report_pkg;

    localparam logic [7:0] SYNC_BYTE     = 8'hA5;
    localparam int         FRAME_BYTES   = 14;
    localparam int         BYTE_IDX_W    = 4;
    localparam int         PAYLOAD_BYTES = FRAME_BYTES - 2;
    localparam int         SNAP_W        = 24;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } tx_state_t;

    function automatic logic [7:0] xor_bytes(input logic [8*PAYLOAD_BYTES-1:0] bytes);
        logic [7:0] acc;
        acc = '0;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            acc = acc ^ bytes[8*i +: 8];
        end
        return acc;
    endfunction

endpackage

// File: rtl/perf_report_tx_uart.sv
// 8N1 byte serialiser; accepts a new byte in the last STOP cycle so frames run back to back.
module uart_tx_byte
    import perf_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       start,
    input  logic [7:0] data,
    output logic       tx,
    output logic       ready,
    output logic       byte_done
);

    localparam int               CNT_W     = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);

    tx_state_t        state_q, state_d;
    logic [CNT_W-1:0] baud_q, baud_d;
    logic [2:0]       bit_q, bit_d;
    logic [7:0]       data_q, data_d;
    logic             tx_q, tx_d;
    logic             baud_wrap;

    assign baud_wrap = (baud_q == BAUD_LAST);
    assign tx        = tx_q;
    assign ready     = (state_q == IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            baud_q  <= '0;
            bit_q   <= '0;
            tx_q    <= 1'b1;
        end else begin
            state_q <= state_d;
            baud_q  <= baud_d;
            bit_q   <= bit_d;
            tx_q    <= tx_d;
        end
        data_q <= data_d;
    end

    always_comb begin
        state_d   = state_q;
        baud_d    = baud_q;
        bit_d     = bit_q;
        data_d    = data_q;
        tx_d      = tx_q;
        byte_done = 1'b0;

        if (state_q != IDLE) begin
            baud_d = baud_wrap ? '0 : baud_q + 1'b1;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = START;
                    baud_d  = '0;
                    data_d  = data;
                    tx_d    = 1'b0;
                end
            end
            START: begin
                if (baud_wrap) begin
                    state_d = DATA;
                    bit_d   = '0;
                    tx_d    = data_q[0];
                end
            end
            DATA: begin
                if (baud_wrap) begin
                    if (bit_q == 3'd7) begin
                        state_d = STOP;
                        tx_d    = 1'b1;
                    end else begin
                        bit_d = bit_q + 3'd1;
                        tx_d  = data_q[bit_q + 3'd1];
                    end
                end
            end
            STOP: begin
                // Last stop cycle: chain straight into the next start bit when one is offered.
                if (baud_wrap) begin
                    byte_done = 1'b1;
                    if (start) begin
                        state_d = START;
                        data_d  = data;
                        tx_d    = 1'b0;
                    end else begin
                        state_d = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

endmodule

// File: rtl/perf_report_tx.sv
// Snapshots the four performance counters on a report trigger and sends them as a
// 14-byte UART frame: sync byte, 12 little-endian payload bytes, XOR checksum.
module perf_report_tx
    import perf_report_pkg::*;
#(
    parameter int CLKS_PER_BIT = 434,
    parameter int COUNTER_W    = 19
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 finish,
    input  logic                 report_req,
    input  logic [COUNTER_W-1:0] R28_stall_count,
    input  logic [COUNTER_W-1:0] R29_aritmetric_count,
    input  logic [COUNTER_W-1:0] R30_memory_count,
    input  logic [COUNTER_W-1:0] R31_cicles_per_inst,
    output logic                 tx,
    output logic                 busy,
    output logic                 done
);

    localparam logic [BYTE_IDX_W-1:0] LAST_IDX = BYTE_IDX_W'(FRAME_BYTES - 1);

    logic                       finish_q;
    logic                       busy_q, busy_d;
    logic                       done_q, done_d;
    logic [BYTE_IDX_W-1:0]      byte_idx_q, byte_idx_d;
    logic [BYTE_IDX_W-1:0]      next_idx;
    logic [8*PAYLOAD_BYTES-1:0] payload_q;
    logic                       snap_load;
    logic                       trig;
    logic                       tx_start;
    logic [7:0]                 tx_data;
    logic                       tx_ready;
    logic                       byte_done;
    logic [7:0]                 frame_byte [FRAME_BYTES];

    assign trig     = (finish & ~finish_q) | report_req;
    assign next_idx = byte_idx_q + 1'b1;
    assign busy     = busy_q;
    assign done     = done_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            finish_q   <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            byte_idx_q <= '0;
        end else begin
            finish_q   <= finish;
            busy_q     <= busy_d;
            done_q     <= done_d;
            byte_idx_q <= byte_idx_d;
        end
    end

    // Counters are frozen here so the whole frame describes one instant.
    always_ff @(posedge clk) begin
        if (snap_load) begin
            payload_q <= {SNAP_W'(R31_cicles_per_inst), SNAP_W'(R30_memory_count),
                          SNAP_W'(R29_aritmetric_count), SNAP_W'(R28_stall_count)};
        end
    end

    always_comb begin
        frame_byte[0] = SYNC_BYTE;
        for (int i = 0; i < PAYLOAD_BYTES; i++) begin
            frame_byte[i+1] = payload_q[8*i +: 8];
        end
        frame_byte[FRAME_BYTES-1] = xor_bytes(payload_q);
    end

    always_comb begin
        busy_d     = busy_q;
        done_d     = 1'b0;
        byte_idx_d = byte_idx_q;
        tx_start   = 1'b0;
        tx_data    = frame_byte[0];
        snap_load  = 1'b0;

        if (!busy_q) begin
            if (trig && tx_ready) begin
                tx_start   = 1'b1;
                busy_d     = 1'b1;
                byte_idx_d = '0;
                snap_load  = 1'b1;
            end
        end else if (byte_done) begin
            if (byte_idx_q < LAST_IDX) begin
                tx_start   = 1'b1;
                byte_idx_d = next_idx;
                tx_data    = frame_byte[next_idx];
            end else begin
                busy_d = 1'b0;
                done_d = 1'b1;
            end
        end
    end

    uart_tx_byte #(
        .CLKS_PER_BIT (CLKS_PER_BIT)
    ) u_uart (
        .clk       (clk),
        .rst       (rst),
        .start     (tx_start),
        .data      (tx_data),
        .tx        (tx),
        .ready     (tx_ready),
        .byte_done (byte_done)
    );

endmodule
